// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, start + NB_DATA data bits (LSB first) + stop.
// Produces a one-clock done pulse with the captured word and a framing-error flag.
module uart_rx #(
   parameter int NB_DATA  = 8,
   parameter int SB_TICK  = 16,
   parameter int NB_STATE = 4
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_rx,
   input  logic               i_tick,
   output logic [NB_DATA-1:0] o_data,
   output logic               o_rx_done_tick,
   output logic               o_frame_err
);

   typedef enum logic [NB_STATE-1:0] {
      IDLE  = NB_STATE'(1),
      START = NB_STATE'(2),
      DATA  = NB_STATE'(4),
      STOP  = NB_STATE'(8)
   } state_t;

   logic               rx_meta_q;
   logic               rx_s_q;
   state_t             state_q, state_d;
   logic [4:0]         s_q, s_d;
   logic [2:0]         n_q, n_d;
   logic [NB_DATA-1:0] b_q, b_d;
   logic [NB_DATA-1:0] data_q, data_d;
   logic               err_q, err_d;
   logic               done_q, done_d;

   // Two-flop synchronizer for the asynchronous serial line; idles high.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= i_rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   // State, counters, shift register and registered outputs.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= IDLE;
         s_q     <= '0;
         n_q     <= '0;
         b_q     <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         b_q     <= b_d;
         data_q  <= data_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic: start detect is immediate, everything else advances on i_tick.
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      b_d     = b_q;
      data_d  = data_q;
      err_d   = err_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rx_s_q) begin
               state_d = START;
               s_d     = '0;
            end
         end
         START: begin
            if (i_tick) begin
               if (s_q == 5'd7) begin
                  if (!rx_s_q) begin
                     state_d = DATA;
                     s_d     = '0;
                     n_d     = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
         DATA: begin
            if (i_tick) begin
               if (s_q == 5'd15) begin
                  s_d = '0;
                  b_d = {rx_s_q, b_q[NB_DATA-1:1]};
                  if (n_q == 3'(NB_DATA - 1)) begin
                     state_d = STOP;
                  end else begin
                     n_d = n_q + 3'd1;
                  end
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
         STOP: begin
            if (i_tick) begin
               if (s_q == 5'(SB_TICK - 1)) begin
                  state_d = IDLE;
                  data_d  = b_q;
                  err_d   = ~rx_s_q;
                  done_d  = 1'b1;
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign o_data         = data_q;
   assign o_frame_err    = err_q;
   assign o_rx_done_tick = done_q;

endmodule
